// File: rtl/line_buffer_3row.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_3row
// Summary  : Three-row line buffer for a raster pixel stream. It keeps the
//            two previous lines in circular line RAMs. From the third line
//            of each frame onward it outputs a vertically aligned triple
//            (top, mid, bot) for every input pixel.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_3row #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic [PIXEL_WIDTH-1:0] pix_top,
    output logic [PIXEL_WIDTH-1:0] pix_mid,
    output logic [PIXEL_WIDTH-1:0] pix_bot,
    output logic                   out_valid,
    output logic                   out_sol,
    output logic                   out_eol,
    output logic                   out_eof
);

    localparam int C_COL_W = $clog2(IMG_WIDTH);
    localparam int C_ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(IMG_WIDTH - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_FILL0  = 2'd0,
        S_FILL1  = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    // lb0 holds line row-1 and lb1 holds line row-2. Neither RAM is reset,
    // because its contents are only exposed after the FILL rows write it.
    logic [PIXEL_WIDTH-1:0] r_lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] r_lb1 [IMG_WIDTH];

    logic [C_COL_W-1:0] r_col;
    logic [C_ROW_W-1:0] r_row;
    state_t             r_state;

    // The effective position of the current pixel. A start-of-frame forces
    // row 0 / col 0 / FILL0 no matter where the counters were.
    logic [C_COL_W-1:0] w_col;
    logic [C_ROW_W-1:0] w_row;
    state_t             w_state;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_sof;

    assign w_sof      = in_valid & in_sof;
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_state    = w_sof ? S_FILL0 : r_state;
    assign w_col_last = (w_col == C_COL_LAST);
    assign w_row_last = (w_row == C_ROW_LAST);

    // Line RAM update: the old row-1 pixel moves down to row-2 and the
    // incoming pixel becomes row-1. Reset drops the pixel, so it does not write.
    always_ff @(posedge clk) begin
        if (!rst && in_valid) begin
            r_lb1[w_col] <= r_lb0[w_col];
            r_lb0[w_col] <= in_pixel;
        end
    end

    // Position counters, frame FSM and registered output triple with flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_state   <= S_FILL0;
            pix_top   <= '0;
            pix_mid   <= '0;
            pix_bot   <= '0;
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else if (in_valid) begin
            // The RAM read happens in the same edge as the write, so it
            // returns the pre-write contents (read-before-write).
            pix_top   <= r_lb1[w_col];
            pix_mid   <= r_lb0[w_col];
            pix_bot   <= in_pixel;
            out_valid <= (w_state == S_STREAM);
            out_sol   <= (w_col == '0);
            out_eol   <= w_col_last;
            out_eof   <= w_col_last & w_row_last;

            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : w_row + C_ROW_W'(1);
            end else begin
                r_col <= w_col + C_COL_W'(1);
                r_row <= w_row;
            end

            case (w_state)
                S_FILL0:  r_state <= w_col_last ? S_FILL1 : S_FILL0;
                S_FILL1:  r_state <= w_col_last ? S_STREAM : S_FILL1;
                S_STREAM: r_state <= (w_col_last & w_row_last) ? S_FILL0 : S_STREAM;
                default:  r_state <= S_FILL0;
            endcase
        end else begin
            // Idle cycle: pixel data holds, and valid and flags drop
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
